// File: rtl/ir_queue.sv
// Instruction prefetch queue: circular buffer with head decode, sticky overflow and flush.
// Latency: a word loaded into an empty queue appears at q one cycle later. Loads are dropped (ovf) when full unless adv frees a slot.
// Optional field decode outputs (opcode/operand) are built when IR_QUEUE_DECODE_EN is defined.
module ir_queue #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int OPC_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld,
  input  logic [WIDTH-1:0]         d,
  input  logic                     adv,
  input  logic                     flush,
  output logic [WIDTH-1:0]         q,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
`ifdef IR_QUEUE_DECODE_EN
  ,
  output logic [OPC_W-1:0]         opcode,
  output logic [WIDTH-OPC_W-1:0]   operand
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             ovf_r;
  logic [WIDTH-1:0] mem [DEPTH];

  logic ld_ok;
  logic adv_ok;

  assign valid  = (cnt != '0);
  assign full   = (cnt == CW'(DEPTH));
  assign count  = cnt;
  assign ovf    = ovf_r;
  assign q      = valid ? mem[rptr] : '0;

  // A full queue can still take a load when the head retires in the same cycle.
  assign ld_ok  = ld && (!full || adv);
  assign adv_ok = adv && valid;

`ifdef IR_QUEUE_DECODE_EN
  assign opcode  = q[WIDTH-1:WIDTH-OPC_W];
  assign operand = q[WIDTH-OPC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      if (ld_ok)
        wptr <= wptr + 1'b1;
      if (adv_ok)
        rptr <= rptr + 1'b1;
      case ({ld_ok, adv_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (ld && !ld_ok)
        ovf_r <= 1'b1;
    end
  end

  // Storage is not reset; stale slots are masked by the count.
  always_ff @(posedge clk) begin
    if (!rst && !flush && ld_ok)
      mem[wptr] <= d;
  end

endmodule

// File: doc/ir_queue.md
IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 Parameter WIDTH, default 12, instruction word width in bits (>=4).
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-003 Parameter OPC_W, default 4, opcode field width taken from the word MSBs (<WIDTH).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset; synchronous and active-high.
REQ-006 Port ld  input  1  load request; writes d into the tail.
REQ-007 Port d  input  WIDTH  instruction word to load.
REQ-008 Port adv  input  1  advance; retires the head entry.
REQ-009 Port flush  input  1  discards all entries (branch redirect).
REQ-010 Port q  output  WIDTH  head instruction; 0 when empty.
REQ-011 Port valid  output  1  queue holds >=1 entry.
REQ-012 Port full  output  1  count == DEPTH.
REQ-013 Port count  output  $clog2(DEPTH)+1  number of held entries.
REQ-014 Port ovf  output  1  sticky: a load was dropped.

Function
REQ-015 Storage SHALL be a circular buffer: write pointer, read pointer, and count, all registered; pointers wrap from DEPTH-1 to 0.
REQ-016 q, valid, full SHALL be combinational decodes of registered state only; no path from ld, adv or d to any output.
REQ-017 Occupancy state SHALL be EMPTY (count=0), PARTIAL (0<count<DEPTH) or FULL (count=DEPTH), moving by at most one step per cycle.
REQ-018 Accepted load SHALL be ld=1 and (not full, or adv=1 in the same cycle).
REQ-019 Accepted advance SHALL be adv=1 and valid=1; adv while empty SHALL be ignored, including in a cycle where ld=1.
REQ-020 Load latency: a word accepted in cycle N SHALL be observable at q in cycle N+1 if the queue was empty, otherwise once all older entries are retired.
REQ-021 ld and adv both accepted in one cycle: count unchanged; head advances; tail written.
REQ-022 ld=1 while full and adv=0: word dropped, storage unchanged, ovf set to 1 next cycle.
REQ-023 ovf SHALL stay set until rst or flush.
REQ-024 flush SHALL take priority over ld and adv: next cycle count=0, both pointers 0, ovf=0, q=0; any ld or adv in that cycle is discarded.
REQ-025 Entries SHALL be returned in strict load order (FIFO).

Reset
REQ-026 rst=1 at a clk edge SHALL set count=0, both pointers 0, ovf=0, with priority over flush, ld and adv.
REQ-027 After reset: q=0, valid=0, full=0, count=0, ovf=0; storage contents need not be cleared.
REQ-028 rst asserted mid-operation SHALL discard all held entries with no partial update.

Configuration
REQ-029 Macro IR_QUEUE_DECODE_EN SHALL control the field-decode outputs.
REQ-030 With the macro defined: extra outputs opcode (OPC_W) = q[WIDTH-1:WIDTH-OPC_W] and operand (WIDTH-OPC_W) = q[WIDTH-OPC_W-1:0], both 0 when empty.
REQ-031 With the macro undefined: opcode and operand SHALL be absent from the port list; all other behaviour identical.

Verification (WIDTH=12, DEPTH=4)
REQ-032 rst=1 for 2 cycles, then rst=0 -> q=0, valid=0, count=0, ovf=0.
REQ-033 ld with d=12'h002 into empty queue -> next cycle q=12'h002, valid=1, count=1; with macro defined, opcode=4'h0 and operand=8'h02.
REQ-034 Load 12'h101, 12'h202, 12'h303, 12'h404, then ld 12'h505 with adv=0 -> full=1, count=4, ovf=1; adv x4 -> q sequence 101,202,303,404; then valid=0.
REQ-035 Full queue with ld=1 (d=12'hAAA) and adv=1 together -> count stays 4, ovf stays 0, 12'hAAA emerges last after 4 advances.
REQ-036 Queue holding 3 entries with flush=1, ld=1 and adv=1 in one cycle -> next cycle count=0, q=0, ovf=0; no entry is written.
REQ-037 adv=1 and ld=1 (d=12'h0F0) while empty -> count=1 and q=12'h0F0 next cycle.
